// File: rtl/seq_pkg.sv
// Shared state encoding and flush-length helper for the convolution layer sequencer.
package seq_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_IM2COL  = 3'd1;
  localparam logic [2:0] ST_FEED    = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_WAIT_SA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_ERR     = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_IM2COL  = ST_IM2COL,
    S_FEED    = ST_FEED,
    S_FLUSH   = ST_FLUSH,
    S_WAIT_SA = ST_WAIT_SA,
    S_DONE    = ST_DONE,
    S_ERR     = ST_ERR
  } state_t;

  // Zero rows needed to drain a systolic array of M rows by K columns.
  function automatic int unsigned flush_len(input int unsigned m, input int unsigned k);
    return m + k - 1;
  endfunction
endpackage

// File: rtl/seq_phase_counter.sv
// Clearable up-counter with terminal-count compare; used for the feed index and phase timing.
module seq_phase_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == term);
endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer control FSM: im2col, operand feed, zero flush, wait for array, done pulse.
// Define SEQ_WATCHDOG_EN to add the IM2COL/WAIT_SA timeout and the sticky ERR state.
module conv_layer_sequencer
  import seq_pkg::*;
#(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int K       = 7,
  parameter int IDX_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             im2col_en,
  input  logic             im2col_done,
  output logic             sa_en,
  input  logic             sa_done,
  output logic             feed_valid,
  output logic [IDX_W-1:0] feed_idx,
  output logic             feed_zero,
  output logic             busy,
  output logic             done,
  output logic             error
);
  localparam int unsigned           FL         = flush_len(M, K);
  localparam logic [IDX_W-1:0]      FEED_LAST  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0]      FLUSH_LAST = IDX_W'(FL - 1);
  localparam logic [IDX_W-1:0]      WD_LAST    = IDX_W'(TIMEOUT - 1);

  state_t           state, nxt;
  logic             sa_seen;
  logic             idx_clr, idx_en, idx_tc;
  logic             ph_clr, ph_en, ph_tc;
  logic [IDX_W-1:0] ph_term;
  logic [IDX_W-1:0] ph_cnt;

  // Feed index: counts through FEED, holds N-1 through FLUSH, zero elsewhere.
  assign idx_clr = !(nxt == S_FEED || nxt == S_FLUSH) || (nxt == S_FEED && state != S_FEED);
  assign idx_en  = (nxt == S_FEED) && (state == S_FEED);

  seq_phase_counter #(.W(IDX_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .clr(idx_clr), .en(idx_en),
    .term(FEED_LAST), .cnt(feed_idx), .tc(idx_tc)
  );

  // Phase counter restarts on every state change; times FLUSH and the watchdog.
  assign ph_clr  = (nxt != state);
  assign ph_en   = (state == S_IM2COL) || (state == S_FLUSH) || (state == S_WAIT_SA);
  assign ph_term = (state == S_FLUSH) ? FLUSH_LAST : WD_LAST;

  seq_phase_counter #(.W(IDX_W)) u_phase (
    .clk(clk), .rst_n(rst_n), .clr(ph_clr), .en(ph_en),
    .term(ph_term), .cnt(ph_cnt), .tc(ph_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start && !abort) nxt = S_IM2COL;
      S_IM2COL: begin
        if (im2col_done) nxt = S_FEED;
`ifdef SEQ_WATCHDOG_EN
        else if (ph_tc)  nxt = S_ERR;
`endif
      end
      S_FEED:    if (idx_tc) nxt = S_FLUSH;
      S_FLUSH:   if (ph_tc)  nxt = S_WAIT_SA;
      S_WAIT_SA: begin
        if (sa_done || sa_seen) nxt = S_DONE;
`ifdef SEQ_WATCHDOG_EN
        else if (ph_tc)         nxt = S_ERR;
`endif
      end
      S_DONE:    nxt = S_IDLE;
`ifdef SEQ_WATCHDOG_EN
      S_ERR:     if (start) nxt = S_IM2COL;
`endif
      default:   nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) nxt = S_IDLE;
  end

  // An early completion from the array must not be lost before WAIT_SA.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              sa_seen <= 1'b0;
    else if (nxt == S_FEED && state != S_FEED) sa_seen <= 1'b0;
    else if (sa_done && (state == S_FEED || state == S_FLUSH)) sa_seen <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im2col_en  <= 1'b0;
      sa_en      <= 1'b0;
      feed_valid <= 1'b0;
      feed_zero  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      im2col_en  <= (nxt == S_IM2COL);
      sa_en      <= (nxt == S_FEED) || (nxt == S_FLUSH) || (nxt == S_WAIT_SA);
      feed_valid <= (nxt == S_FEED);
      feed_zero  <= (nxt == S_FLUSH);
      busy       <= (nxt != S_IDLE) && (nxt != S_ERR);
      done       <= (nxt == S_DONE);
    end
  end

`ifdef SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                error <= 1'b0;
    else if (nxt == S_ERR)     error <= 1'b1;
    else if (nxt == S_IM2COL)  error <= 1'b0;
  end
`else
  assign error = 1'b0;
`endif
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer (M=16, N=16, K=7, flush 22 cycles).
module tb_conv_layer_sequencer;
  logic        clk, rst_n, start, abort, im2col_done, sa_done;
  logic        im2col_en, sa_en, feed_valid, feed_zero, busy, done, error;
  logic [15:0] feed_idx;
  int cmp = 0, bad = 0;

  conv_layer_sequencer #(.M(16), .N(16), .K(7), .IDX_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .im2col_en(im2col_en), .im2col_done(im2col_done),
    .sa_en(sa_en), .sa_done(sa_done),
    .feed_valid(feed_valid), .feed_idx(feed_idx), .feed_zero(feed_zero),
    .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 0; abort = 0; im2col_done = 0; sa_done = 0;
    #2 rst_n = 1'b0;
    #1;
    cmp++; if ({im2col_en, sa_en, feed_valid, feed_idx, feed_zero, busy, done, error} !== 23'd0) begin
      bad++; $display("FAIL reset_outs: got %0h want 0",
        {im2col_en, sa_en, feed_valid, feed_idx, feed_zero, busy, done, error});
    end
    tick; tick; rst_n = 1'b1; tick;
    cmp++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic;
    start = 1; tick; start = 0;
    cmp++; if (im2col_en !== 1 || busy !== 1 || sa_en !== 0) begin
      bad++; $display("FAIL im2col_entry: en=%b busy=%b sa_en=%b want 1 1 0", im2col_en, busy, sa_en);
    end
    repeat (4) tick;
    cmp++; if (im2col_en !== 1) begin bad++; $display("FAIL im2col_hold: en=%b want 1", im2col_en); end
    im2col_done = 1; tick; im2col_done = 0;
    for (int i = 0; i < 16; i++) begin
      cmp++; if (feed_valid !== 1 || feed_idx !== 16'(i) || sa_en !== 1 || im2col_en !== 0 || feed_zero !== 0) begin
        bad++; $display("FAIL feed_%0d: valid=%b idx=%0d sa_en=%b im2col_en=%b want 1 %0d 1 0", i, feed_valid, feed_idx, sa_en, im2col_en, i);
      end
      tick;
    end
    for (int i = 0; i < 22; i++) begin
      cmp++; if (feed_zero !== 1 || feed_valid !== 0 || feed_idx !== 16'd15 || sa_en !== 1) begin
        bad++; $display("FAIL flush_%0d: zero=%b valid=%b idx=%0d sa_en=%b want 1 0 15 1", i, feed_zero, feed_valid, feed_idx, sa_en);
      end
      tick;
    end
    cmp++; if (sa_en !== 1 || feed_zero !== 0 || done !== 0 || busy !== 1) begin
      bad++; $display("FAIL wait_sa: sa_en=%b zero=%b done=%b busy=%b want 1 0 0 1", sa_en, feed_zero, done, busy);
    end
    sa_done = 1; tick; sa_done = 0;
    cmp++; if (done !== 1 || sa_en !== 0 || busy !== 1 || error !== 0) begin
      bad++; $display("FAIL done_pulse: done=%b sa_en=%b busy=%b err=%b want 1 0 1 0", done, sa_en, busy, error);
    end
    tick;
    cmp++; if (done !== 0 || busy !== 0) begin
      bad++; $display("FAIL back_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_start_busy;
    int nf = 0, nd = 0, seq_err = 0;
    start = 1; tick; start = 0; im2col_done = 1; tick; im2col_done = 0;
    for (int i = 0; i < 60; i++) begin
      start   = feed_valid && (feed_idx == 16'd3);
      sa_done = sa_en && !feed_valid && !feed_zero;
      if (feed_valid) begin if (feed_idx !== 16'(nf)) seq_err++; nf++; end
      if (done) nd++;
      tick;
    end
    start = 0; sa_done = 0;
    cmp++; if (nf != 16 || seq_err != 0) begin
      bad++; $display("FAIL busy_feed_seq: feeds=%0d breaks=%0d want 16 0", nf, seq_err);
    end
    cmp++; if (nd != 1) begin bad++; $display("FAIL busy_done_cnt: got %0d want 1", nd); end
    cmp++; if (busy !== 0) begin bad++; $display("FAIL busy_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_abort;
    int nd = 0;
    start = 1; tick; start = 0; im2col_done = 1; tick; im2col_done = 0;
    repeat (16) tick;
    tick; tick;
    cmp++; if (feed_zero !== 1) begin bad++; $display("FAIL abort_pre: zero=%b want 1", feed_zero); end
    abort = 1; tick; abort = 0;
    cmp++; if (busy !== 0 || sa_en !== 0 || feed_zero !== 0 || done !== 0 || feed_idx !== 0) begin
      bad++; $display("FAIL abort_idle: busy=%b sa_en=%b zero=%b done=%b idx=%0d want 0 0 0 0 0", busy, sa_en, feed_zero, done, feed_idx);
    end
    for (int i = 0; i < 40; i++) begin if (done) nd++; tick; end
    cmp++; if (nd != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", nd); end
  endtask

  task automatic test_early_sa;
    int done_at = -1, nwait = 0;
    start = 1; tick; start = 0;
    im2col_done = 1;
    for (int i = 1; i <= 50; i++) begin
      if (i == 2) begin im2col_done = 0; sa_done = 1; end
      if (sa_en && !feed_valid && !feed_zero) nwait++;
      if (done && done_at < 0) done_at = i;
      tick;
    end
    sa_done = 0;
    cmp++; if (done_at != 41) begin bad++; $display("FAIL early_sa_latency: got %0d want 41", done_at); end
    cmp++; if (nwait != 1) begin bad++; $display("FAIL early_sa_wait: got %0d want 1", nwait); end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    start = 1; tick; start = 0; im2col_done = 1; tick; im2col_done = 0;
    repeat (7) tick;
    cmp++; if (feed_idx !== 16'd7) begin bad++; $display("FAIL mid_idx: got %0d want 7", feed_idx); end
    #2 rst_n = 0; #1;
    cmp++; if ({im2col_en, sa_en, feed_valid, feed_idx, feed_zero, busy, done, error} !== 23'd0) begin
      bad++; $display("FAIL mid_reset_outs: got %0h want 0",
        {im2col_en, sa_en, feed_valid, feed_idx, feed_zero, busy, done, error});
    end
    tick; rst_n = 1; tick;
    cmp++; if (busy !== 0) begin bad++; $display("FAIL mid_reset_idle: busy=%b want 0", busy); end
    start = 1; tick; start = 0; im2col_done = 1; tick; im2col_done = 0;
    cmp++; if (feed_valid !== 1 || feed_idx !== 16'd0) begin
      bad++; $display("FAIL restart_idx0: valid=%b idx=%0d want 1 0", feed_valid, feed_idx);
    end
    tick;
    cmp++; if (feed_idx !== 16'd1) begin bad++; $display("FAIL restart_idx1: got %0d want 1", feed_idx); end
    for (int i = 0; i < 60; i++) begin
      sa_done = sa_en && !feed_valid && !feed_zero;
      if (done) nd++;
      tick;
    end
    sa_done = 0;
    cmp++; if (nd != 1) begin bad++; $display("FAIL restart_done: got %0d want 1", nd); end
  endtask

`ifdef SEQ_WATCHDOG_EN
  task automatic test_watchdog;
    int nd = 0;
    start = 1; tick; start = 0;
    repeat (63) tick;
    cmp++; if (im2col_en !== 1 || error !== 0) begin
      bad++; $display("FAIL wd_before: en=%b err=%b want 1 0", im2col_en, error);
    end
    tick;
    cmp++; if (error !== 1 || busy !== 0 || im2col_en !== 0) begin
      bad++; $display("FAIL wd_trip: err=%b busy=%b en=%b want 1 0 0", error, busy, im2col_en);
    end
    repeat (3) tick;
    cmp++; if (error !== 1) begin bad++; $display("FAIL wd_sticky: err=%b want 1", error); end
    start = 1; tick; start = 0;
    cmp++; if (error !== 0 || im2col_en !== 1 || busy !== 1) begin
      bad++; $display("FAIL wd_clear: err=%b en=%b busy=%b want 0 1 1", error, im2col_en, busy);
    end
    im2col_done = 1; tick; im2col_done = 0;
    for (int i = 0; i < 60; i++) begin
      sa_done = sa_en && !feed_valid && !feed_zero;
      if (done) nd++;
      tick;
    end
    sa_done = 0;
    cmp++; if (nd != 1 || error !== 0) begin
      bad++; $display("FAIL wd_rerun: dones=%0d err=%b want 1 0", nd, error);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_start_busy;
    test_abort;
    test_early_sa;
    test_reset_mid;
`ifdef SEQ_WATCHDOG_EN
    test_watchdog;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
